vga_console_writer: RTL and testbench

- Producer side of the 70x30 VGA text buffer: accepts ASCII bytes from the CPU/IO bus over a valid/ready handshake.
- Writes each byte into the character RAM at the cursor position; the VGA scanout reads that RAM on its other port.
- Handles cursor advance, line wrap, newline, carriage return, backspace, form-feed clear, and hardware scroll-up.

---
 rtl/vga_console_pkg.sv | 39 +++
 rtl/vga_cursor.sv | 81 ++++++++
 rtl/vga_console_writer.sv | 173 +++++++++++++++++
 tb/tb_vga_console_writer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_console_pkg.sv
// Shared constants, state type and cursor command type for the VGA console writer.
// VGA_CONSOLE_CLR_ON_RST_EN adds the CLR_ALL state used for clear-on-reset.
package vga_console_pkg;

  localparam int COLS_DEF   = 70;
  localparam int ROWS_DEF   = 30;
  localparam int ADDR_W_DEF = 12;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    SCR_RD,
    SCR_WR,
    CLR
`ifdef VGA_CONSOLE_CLR_ON_RST_EN
    , CLR_ALL
`endif
  } state_t;

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_ADV,
    CUR_NL,
    CUR_CR,
    CUR_BS,
    CUR_HOME
  } cur_op_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/vga_cursor.sv
// Cursor position registers with advance/newline/backspace rules and the
// linear cell address row*70 + col built from shifts.
module vga_cursor
  import vga_console_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  cur_op_t           op,
  output logic [6:0]        x,
  output logic [4:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              at_right,
  output logic              at_bottom,
  output logic              at_origin
);

  logic [6:0]        x_nx;
  logic [4:0]        y_nx;
  logic [ADDR_W-1:0] y_ext;

  assign at_right  = (x == 7'(COLS - 1));
  assign at_bottom = (y == 5'(ROWS - 1));
  assign at_origin = (x == 7'd0) && (y == 5'd0);

  // row*70 = row*64 + row*4 + row*2
  assign y_ext = ADDR_W'(y);
  assign addr  = (y_ext << 6) + (y_ext << 2) + (y_ext << 1) + ADDR_W'(x);

  always_comb begin
    x_nx = x;
    y_nx = y;
    case (op)
      CUR_ADV: begin
        if (!at_right) begin
          x_nx = x + 7'd1;
        end else begin
          x_nx = 7'd0;
          y_nx = at_bottom ? y : (y + 5'd1);
        end
      end
      CUR_NL: begin
        x_nx = 7'd0;
        y_nx = at_bottom ? y : (y + 5'd1);
      end
      CUR_CR: x_nx = 7'd0;
      CUR_BS: begin
        if (x != 7'd0) begin
          x_nx = x - 7'd1;
        end else if (y != 5'd0) begin
          x_nx = 7'(COLS - 1);
          y_nx = y - 5'd1;
        end else begin
          x_nx = x;
        end
      end
      CUR_HOME: begin
        x_nx = 7'd0;
        y_nx = 5'd0;
      end
      default: begin
        x_nx = x;
        y_nx = y;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= 7'd0;
      y <= 5'd0;
    end else begin
      x <= x_nx;
      y <= y_nx;
    end
  end

endmodule

// File: rtl/vga_console_writer.sv
// Producer side of the 70x30 text buffer: byte handshake, cursor control, scroll and clear.
// Define VGA_CONSOLE_CLR_ON_RST_EN to blank every cell after reset (CLR_ALL state).
module vga_console_writer
  import vga_console_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [31:0]       buf_wdata,
  input  logic [31:0]       buf_rdata,
  output logic [6:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_SRC  = ADDR_W'((ROWS - 1) * COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);

  state_t            state, state_nx;
  logic [7:0]        char_r, char_nx;
  logic [ADDR_W-1:0] ptr_r, ptr_nx;
  logic [ADDR_W-1:0] end_r, end_nx;
  logic              home_r, home_nx;
  cur_op_t           cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic              at_right, at_bottom, at_origin;

  vga_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
    .clk       (sys_clk),
    .rst       (rst),
    .op        (cur_op),
    .x         (cursor_x),
    .y         (cursor_y),
    .addr      (cur_addr),
    .at_right  (at_right),
    .at_bottom (at_bottom),
    .at_origin (at_origin)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // ptr_r walks the scroll destination, then the cleared cells up to end_r
  always_comb begin
    state_nx  = state;
    char_nx   = char_r;
    ptr_nx    = ptr_r;
    end_nx    = end_r;
    home_nx   = home_r;
    cur_op    = CUR_HOLD;
    buf_we    = 1'b0;
    buf_addr  = '0;
    buf_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (!in_valid) begin
          state_nx = IDLE;
        end else if (is_printable(in_char)) begin
          char_nx  = in_char;
          state_nx = PUT;
        end else begin
          case (in_char)
            CH_LF: begin
              cur_op = CUR_NL;
              if (at_bottom) begin
                ptr_nx   = '0;
                state_nx = SCR_RD;
              end else begin
                state_nx = IDLE;
              end
            end
            CH_CR: cur_op = CUR_CR;
            CH_BS: begin
              // the cell left of the cursor, wrapping to the previous row, is always addr-1
              if (!at_origin) begin
                cur_op   = CUR_BS;
                ptr_nx   = cur_addr - ADDR_W'(1);
                end_nx   = cur_addr - ADDR_W'(1);
                home_nx  = 1'b0;
                state_nx = CLR;
              end else begin
                state_nx = IDLE;
              end
            end
            CH_FF: begin
              ptr_nx   = '0;
              end_nx   = LAST_CELL;
              home_nx  = 1'b1;
              state_nx = CLR;
            end
            default: state_nx = IDLE;
          endcase
        end
      end
      PUT: begin
        buf_we    = 1'b1;
        buf_addr  = cur_addr;
        buf_wdata = {24'h0, char_r};
        cur_op    = CUR_ADV;
        if (at_right && at_bottom) begin
          ptr_nx   = '0;
          state_nx = SCR_RD;
        end else begin
          state_nx = IDLE;
        end
      end
      SCR_RD: begin
        buf_addr = ptr_r + ROW_STEP;
        state_nx = SCR_WR;
      end
      SCR_WR: begin
        buf_we    = 1'b1;
        buf_addr  = ptr_r;
        buf_wdata = buf_rdata;
        ptr_nx    = ptr_r + ADDR_W'(1);
        if (ptr_r == LAST_SRC) begin
          end_nx   = LAST_CELL;
          home_nx  = 1'b0;
          state_nx = CLR;
        end else begin
          state_nx = SCR_RD;
        end
      end
      CLR
`ifdef VGA_CONSOLE_CLR_ON_RST_EN
      , CLR_ALL
`endif
      : begin
        buf_we    = 1'b1;
        buf_addr  = ptr_r;
        buf_wdata = {24'h0, CH_SP};
        ptr_nx    = ptr_r + ADDR_W'(1);
        if (ptr_r == end_r) begin
          state_nx = IDLE;
          cur_op   = home_r ? CUR_HOME : CUR_HOLD;
        end else begin
          state_nx = state;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
`ifdef VGA_CONSOLE_CLR_ON_RST_EN
      state  <= CLR_ALL;
`else
      state  <= IDLE;
`endif
      char_r <= 8'h00;
      ptr_r  <= '0;
      end_r  <= LAST_CELL;
      home_r <= 1'b1;
    end else begin
      state  <= state_nx;
      char_r <= char_nx;
      ptr_r  <= ptr_nx;
      end_r  <= end_nx;
      home_r <= home_nx;
    end
  end

endmodule

// File: tb/tb_vga_console_writer.sv
// Randomized bench for vga_console_writer: a screen/cursor model built from the
// console rules is compared with a sync-read RAM written by the DUT after every byte.
module tb_vga_console_writer;

  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int AW    = 12;
  localparam int CELLS = COLS * ROWS;
  localparam int SCROLL_BUSY = 2 * (ROWS - 1) * COLS + COLS;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_char = 8'h00;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [31:0]   buf_wdata;
  logic [31:0]   buf_rdata;
  logic [6:0]    cursor_x;
  logic [4:0]    cursor_y;
  logic          busy;

  always #5 sys_clk = ~sys_clk;

  vga_console_writer dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_wdata (buf_wdata),
    .buf_rdata (buf_rdata),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .busy      (busy)
  );

  logic [7:0]    ram [0:CELLS-1];
  logic [7:0]    scr [0:CELLS-1];
  logic          fill_on = 1'b0;
  int            wr_count = 0;
  int            bad_addr = 0;
  int            bad_upper = 0;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_wdata = 32'h0;
  int            cx = 0;
  int            cy = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  // character RAM with one-cycle read latency, plus write monitor
  always @(posedge sys_clk) begin
    buf_rdata <= (int'(buf_addr) < CELLS) ? {24'h0, ram[buf_addr]} : 32'h0;
    if (fill_on) begin
      for (int i = 0; i < CELLS; i++) ram[i] <= scr[i];
    end
    if (buf_we) begin
      wr_count   <= wr_count + 1;
      last_addr  <= buf_addr;
      last_wdata <= buf_wdata;
      if (int'(buf_addr) < CELLS) ram[buf_addr] <= buf_wdata[7:0];
      else bad_addr <= bad_addr + 1;
      if (buf_wdata[31:8] != 24'h0) bad_upper <= bad_upper + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int mismatches();
    int n = 0;
    for (int i = 0; i < CELLS; i++) if (ram[i] !== scr[i]) n++;
    return n;
  endfunction

  task automatic model_scroll();
    for (int r = 1; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[(r - 1) * COLS + c] = scr[r * COLS + c];
    for (int c = 0; c < COLS; c++) scr[(ROWS - 1) * COLS + c] = 8'h20;
  endtask

  // expected effect of one byte: screen, cursor, write count, busy cycles
  task automatic model_step(input logic [7:0] c, output int ew, output int eb);
    ew = 0;
    eb = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      scr[cy * COLS + cx] = c;
      ew = 1;
      eb = 1;
      if (cx < COLS - 1) cx++;
      else begin
        cx = 0;
        if (cy < ROWS - 1) cy++;
        else begin
          model_scroll();
          ew += CELLS;
          eb += SCROLL_BUSY;
        end
      end
    end else if (c == 8'h0A) begin
      cx = 0;
      if (cy < ROWS - 1) cy++;
      else begin
        model_scroll();
        ew = CELLS;
        eb = SCROLL_BUSY;
      end
    end else if (c == 8'h0D) begin
      cx = 0;
    end else if (c == 8'h08) begin
      if (cx > 0 || cy > 0) begin
        if (cx > 0) cx--;
        else begin
          cx = COLS - 1;
          cy--;
        end
        scr[cy * COLS + cx] = 8'h20;
        ew = 1;
        eb = 1;
      end
    end else if (c == 8'h0C) begin
      for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
      cx = 0;
      cy = 0;
      ew = CELLS;
      eb = CELLS;
    end
  endtask

  task automatic send(input logic [7:0] c);
    int ew, eb, cyc, w0;
    model_step(c, ew, eb);
    @(negedge sys_clk);
    chk("ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_char  = c;
    w0 = wr_count;
    @(negedge sys_clk);
    in_valid = 1'b0;
    in_char  = 8'($urandom);
    cyc = 0;
    while (!in_ready && cyc < 20000) begin
      cyc++;
      @(negedge sys_clk);
    end
    chk("busy_cycles", 32'(cyc), 32'(eb));
    chk("writes", 32'(wr_count - w0), 32'(ew));
    chk("cursor_x", 32'(cursor_x), 32'(cx));
    chk("cursor_y", 32'(cursor_y), 32'(cy));
    chk("screen", 32'(mismatches()), 32'd0);
  endtask

  task automatic do_reset();
    int cyc, w0;
    @(negedge sys_clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge sys_clk);
    w0 = wr_count;
    rst = 1'b0;
`ifdef VGA_CONSOLE_CLR_ON_RST_EN
    cyc = 0;
    while (!in_ready && cyc < 5000) begin
      cyc++;
      @(negedge sys_clk);
    end
    chk("clr_all_busy", 32'(cyc), 32'(CELLS));
    chk("clr_all_writes", 32'(wr_count - w0), 32'(CELLS));
    for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
    chk("clr_all_screen", 32'(mismatches()), 32'd0);
`else
    cyc = 0;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(buf_we), 32'd0);
    chk("rst_addr", 32'(buf_addr), 32'd0);
    chk("rst_wdata", buf_wdata, 32'd0);
    @(negedge sys_clk);
    chk("rst_no_writes", 32'(wr_count - w0 + cyc), 32'd0);
    // contents after an aborted scroll are unspecified; adopt them
    for (int i = 0; i < CELLS; i++) scr[i] = ram[i];
`endif
    cx = 0;
    cy = 0;
    chk("rst_cursor_x", 32'(cursor_x), 32'd0);
    chk("rst_cursor_y", 32'(cursor_y), 32'd0);
  endtask

  initial begin
    int v;
    logic [7:0] c;
    for (int i = 0; i < CELLS; i++) scr[i] = 8'($urandom_range(33, 126));
    fill_on = 1'b1;
    repeat (2) @(negedge sys_clk);
    fill_on = 1'b0;
    do_reset();
    chk("init_screen", 32'(mismatches()), 32'd0);

    send(8'h41);
    chk("a_addr", 32'(last_addr), 32'd0);
    chk("a_wdata", last_wdata, 32'h41);
    send(8'h08);
    send(8'h08);
    for (int i = 0; i < COLS; i++) send(8'h42);
    chk("row_last_addr", 32'(last_addr), 32'd69);
    send(8'h08);
    chk("bs_wrap_addr", 32'(last_addr), 32'd69);
    send(8'h0D);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'($urandom_range(33, 126)));
    send(8'h0A);
    send(8'h07);
    send(8'h0C);
    chk("ff_last_addr", 32'(last_addr), 32'(CELLS - 1));

    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    for (int n = 0; n < 150; n++) begin
      v = int'($urandom_range(0, 99));
      if (v < 76) c = 8'($urandom_range(32, 126));
      else if (v < 80) c = 8'h0A;
      else if (v < 85) c = 8'h0D;
      else if (v < 92) c = 8'h08;
      else if (v < 94) c = 8'h0C;
      else if (v < 97) c = 8'($urandom_range(127, 255));
      else begin
        c = 8'($urandom_range(0, 31));
        if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'h1B;
      end
      send(c);
    end

    send(8'h0D);
    for (int i = 0; i < ROWS && cy < ROWS - 1; i++) send(8'h0A);
    @(negedge sys_clk);
    in_valid = 1'b1;
    in_char  = 8'h0A;
    @(negedge sys_clk);
    in_valid = 1'b0;
    repeat (100) @(negedge sys_clk);
    chk("scroll_busy", 32'(busy), 32'd1);
    do_reset();
    send(8'h5A);
    send(8'h79);

    chk("bad_addr", 32'(bad_addr), 32'd0);
    chk("bad_upper", 32'(bad_upper), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
